// File: rtl/ring_phase_monitor_if.sv
// Interface for ring_phase_monitor: the sampled ring bus, the error clear
// and every registered status output.
// master: the side that drives ring_in/clr_err and observes the status.
// slave:  the monitor itself.
interface ring_phase_monitor_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned REV_W = 8
);
    localparam int unsigned PW = $clog2(WIDTH);

    logic [WIDTH-1:0] ring_in;
    logic             clr_err;
    logic [PW-1:0]    phase;
    logic             phase_valid;
    logic             locked;
    logic             rev_tick;
    logic [REV_W-1:0] rev_count;
    logic             err_pulse;
    logic             err_sticky;
    logic [7:0]       err_count;

    modport master (
        output ring_in, clr_err,
        input  phase, phase_valid, locked, rev_tick, rev_count,
               err_pulse, err_sticky, err_count
    );

    modport slave (
        input  ring_in, clr_err,
        output phase, phase_valid, locked, rev_tick, rev_count,
               err_pulse, err_sticky, err_count
    );
endinterface

// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor: checks a one-hot ring counter bus for legality and
// rotation direction, encodes the phase index, locks after LOCK_CNT good
// steps, counts locked revolutions and flags faults while locked.
// Optional macro RING_PHASE_ERR_CNT_EN: enables the 8-bit saturating
// err_count; without it err_count is tied to zero.
module ring_phase_monitor #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned LOCK_CNT   = 2,
    parameter int unsigned SHIFT_LEFT = 1,
    parameter int unsigned REV_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    ring_phase_monitor_if.slave  bus
);
    localparam int unsigned PW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_prev;
    logic [3:0]       r_good_cnt;
    logic [3:0]       w_good_cnt_nxt;

    logic [PW-1:0]    r_phase;
    logic             r_phase_valid;
    logic             r_locked;
    logic             r_rev_tick;
    logic [REV_W-1:0] r_rev_count;
    logic             r_err_pulse;
    logic             r_err_sticky;

    logic [WIDTH-1:0] w_rot;
    logic             w_legal;
    logic             w_step_ok;
    logic             w_wrap_bit;
    logic             w_fault;
    logic             w_tick;
    logic [PW-1:0]    w_enc;
    logic [PW-1:0]    w_phase_nxt;
    logic [REV_W-1:0] w_rev_nxt;
    logic             w_sticky_nxt;

    // Expected successor of the previous sample and per-sample qualifiers
    always_comb begin
        if (SHIFT_LEFT != 0) begin
            w_rot      = {r_prev[WIDTH-2:0], r_prev[WIDTH-1]};
            w_wrap_bit = bus.ring_in[0];
        end else begin
            w_rot      = {r_prev[0], r_prev[WIDTH-1:1]};
            w_wrap_bit = bus.ring_in[WIDTH-1];
        end
        w_legal   = $onehot(bus.ring_in);
        w_step_ok = w_legal && (bus.ring_in == w_rot);
        w_fault   = (r_state == ST_LOCKED) && !w_step_ok;
        w_tick    = (r_state == ST_LOCKED) && w_step_ok && w_wrap_bit;
    end

    // One-hot to binary index of the set bit
    always_comb begin
        w_enc = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (bus.ring_in[i]) w_enc = PW'(i);
        end
    end

    // State register plus all registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_prev        <= '0;
            r_good_cnt    <= '0;
            r_phase       <= '0;
            r_phase_valid <= 1'b0;
            r_locked      <= 1'b0;
            r_rev_tick    <= 1'b0;
            r_rev_count   <= '0;
            r_err_pulse   <= 1'b0;
            r_err_sticky  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_prev        <= bus.ring_in;
            r_good_cnt    <= w_good_cnt_nxt;
            r_phase       <= w_phase_nxt;
            r_phase_valid <= w_legal;
            r_locked      <= (w_state_nxt == ST_LOCKED);
            r_rev_tick    <= w_tick;
            r_rev_count   <= w_rev_nxt;
            r_err_pulse   <= w_fault;
            r_err_sticky  <= w_sticky_nxt;
        end
    end

    // Next-state and good-step counter
    always_comb begin
        w_state_nxt    = r_state;
        w_good_cnt_nxt = r_good_cnt;
        case (r_state)
            ST_IDLE, ST_FAULT: begin
                if (w_legal) begin
                    w_state_nxt    = ST_SYNC;
                    w_good_cnt_nxt = '0;
                end
            end
            ST_SYNC: begin
                if (!w_legal) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_step_ok) begin
                    w_good_cnt_nxt = r_good_cnt + 4'd1;
                    if (r_good_cnt + 4'd1 == 4'(LOCK_CNT)) w_state_nxt = ST_LOCKED;
                end else begin
                    w_good_cnt_nxt = '0;
                end
            end
            ST_LOCKED: begin
                if (!w_step_ok) w_state_nxt = ST_FAULT;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        w_phase_nxt  = w_legal ? w_enc : r_phase;
        w_rev_nxt    = w_tick ? (r_rev_count + REV_W'(1)) : r_rev_count;
        w_sticky_nxt = r_err_sticky;
        if (w_fault)          w_sticky_nxt = 1'b1;
        else if (bus.clr_err) w_sticky_nxt = 1'b0;
    end

`ifdef RING_PHASE_ERR_CNT_EN
    logic [7:0] r_err_count;

    // Saturating fault counter; a fault in a clear cycle leaves it at 1
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err_count <= '0;
        end else if (w_fault) begin
            if (bus.clr_err)            r_err_count <= 8'd1;
            else if (r_err_count != '1) r_err_count <= r_err_count + 8'd1;
        end else if (bus.clr_err) begin
            r_err_count <= '0;
        end
    end

    assign bus.err_count = r_err_count;
`else
    assign bus.err_count = '0;
`endif

    assign bus.phase       = r_phase;
    assign bus.phase_valid = r_phase_valid;
    assign bus.locked      = r_locked;
    assign bus.rev_tick    = r_rev_tick;
    assign bus.rev_count   = r_rev_count;
    assign bus.err_pulse   = r_err_pulse;
    assign bus.err_sticky  = r_err_sticky;
endmodule

// File: doc/ring_phase_monitor.md
Name: ring_phase_monitor

Overview:
- Sits directly downstream of the 4-bit one-hot ring counter and consumes its q_out bus every clock.
- Checks that the bus stays legal one-hot and rotates in the expected direction, then encodes it to a binary phase index.
- Locks after a run of correct steps, counts full revolutions, and flags faults for the control/debug logic.
- All outputs are registered.

Parameters:
- WIDTH, 4: ring width. Minimum 2.
- LOCK_CNT, 2: consecutive correct rotations needed to enter LOCKED. Range 1..15.
- SHIFT_LEFT, 1: 1 means expected next = {prev[WIDTH-2:0], prev[WIDTH-1]} (0001->0010). 0 means rotate right.
- REV_W, 8: revolution counter width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (rst=0 resets on the next rising clk edge).
- ring_in  in  WIDTH  one-hot ring counter output (q_out of the upstream counter).
- clr_err  in  1  synchronous clear of err_sticky and err_count. Lower priority than rst.
- phase  out  $clog2(WIDTH)  binary index of the set bit of the last sample.
- phase_valid  out  1  last sample was legal one-hot.
- locked  out  1  high while state is LOCKED.
- rev_tick  out  1  one-cycle pulse on each locked wrap to bit 0.
- rev_count  out  REV_W  revolutions since reset; wraps modulo 2^REV_W.
- err_pulse  out  1  one-cycle pulse on a detected fault.
- err_sticky  out  1  set on any fault; held until rst or clr_err.
- err_count  out  8  fault counter (see Optional Feature).

Behaviour:
Reset:
- When rst=0 at an edge: state=IDLE, prev=0, good_cnt=0.
- All outputs are 0 after that edge.

Sampling and latency:
- Each edge with rst=1, ring_in is sampled.
- legal = exactly one bit set. step_ok = (ring_in == rot(prev)).
- prev <= ring_in every cycle, whether or not the sample is legal.
- phase and phase_valid reflect the sample taken at that edge, visible after it (1-cycle latency).
- phase holds its previous value when the sample is illegal.

FSM (state seen at the edge determines the action):
- IDLE: legal -> SYNC with good_cnt=0. Illegal -> stay IDLE. No error is raised in IDLE.
- SYNC:
  - legal && step_ok: good_cnt+1. If it reaches LOCK_CNT -> LOCKED.
  - legal && !step_ok: good_cnt=0, stay SYNC.
  - illegal: -> IDLE.
  - No errors are raised in SYNC.
- LOCKED:
  - legal && step_ok: stay LOCKED.
  - Anything else is a fault: illegal code, stall (ring_in==prev), wrong direction, or skip. On a fault -> FAULT, err_pulse=1 for one cycle, err_sticky=1, err_count increments.
- FAULT: legal -> SYNC with good_cnt=0. Illegal -> stay FAULT. No further err_pulse while in FAULT.

Outputs and counters:
- locked=1 exactly while state==LOCKED, visible after the edge that enters LOCKED.
- rev_tick=1 and rev_count+1 when state==LOCKED at the edge, step_ok, and ring_in[0]=1 for SHIFT_LEFT=1 (ring_in[WIDTH-1]=1 for SHIFT_LEFT=0).
- The edge that enters LOCKED never ticks.

Simultaneous events:
- rst=0 overrides everything.
- A fault and clr_err in the same cycle: err_sticky ends 1, err_count ends 1.
- rev_count is not cleared by clr_err.

Optional Feature:
- Macro: RING_PHASE_ERR_CNT_EN.
- Defined: err_count is an 8-bit saturating counter (stops at 255). It increments on each err_pulse and is cleared by rst or clr_err.
- Undefined: the counter logic is absent and err_count is tied to 8'd0. The port list is identical in both builds.

Test Plan (defaults WIDTH=4, LOCK_CNT=2, SHIFT_LEFT=1):
1. Reset: rst=0 for 2 edges while ring_in=0001 -> all outputs 0. Release rst -> state IDLE; next edge phase_valid=1, phase=0.
2. Acquisition: drive 0001,0010,0100,1000 on edges 1-4 -> locked=0 after edges 1-2, locked=1 after edge 3; phase reads 0,1,2,3; no rev_tick.
3. Revolutions: continue rotating for 3 full cycles after lock -> rev_tick pulses on each 1000->0001 edge; rev_count=1,2,3; err_sticky=0.
4. Illegal code while locked: inject 0110 -> err_pulse for one cycle, locked=0, phase_valid=0, err_sticky=1, err_count=1. Then 0001,0010,0100 -> relock after the 0100 edge; err_sticky still 1 until clr_err=1 for one edge, then 0/0.
5. Stall and reverse while locked: repeat 0100 twice -> fault. Reacquire, then drive 0010 after 0100 -> second fault, err_count=2. With macro undefined, err_count stays 0.
6. Mid-operation reset: rst=0 for one edge while locked with rev_count=5 -> all outputs 0 and state IDLE after that edge. Relock takes a full acquisition again.
